// File: rtl/ann_burst_memory.sv
// ann_burst_memory: layer-indexed parameter store with independent burst read and burst write channels.
// Latency: first read beat one cycle after request acceptance, then one beat per cycle; write done one cycle after last commit.
// Backpressure: each channel takes a new request only when idle (no queueing); write beats may stall with i_wr_valid gaps.
module ann_burst_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int LAYER_WIDTH  = 2,
  parameter int NUM_LAYERS   = 3,
  parameter int OFFSET_WIDTH = 11,
  parameter int BURST_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_rd_req,
  input  logic [LAYER_WIDTH-1:0]  i_rd_layer,
  input  logic [OFFSET_WIDTH-1:0] i_rd_addr,
  input  logic [BURST_WIDTH-1:0]  i_rd_len,
  output logic                    o_rd_ready,
  output logic                    o_rd_valid,
  output logic [LAYER_WIDTH-1:0]  o_rd_layer,
  output logic [OFFSET_WIDTH-1:0] o_rd_addr,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_last,
  output logic                    o_rd_err,
  input  logic                    i_wr_req,
  input  logic                    i_wr_mode,
  input  logic [LAYER_WIDTH-1:0]  i_wr_layer,
  input  logic [OFFSET_WIDTH-1:0] i_wr_addr,
  input  logic [BURST_WIDTH-1:0]  i_wr_len,
  input  logic                    i_wr_valid,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  output logic                    o_wr_ready,
  output logic                    o_wr_done,
  output logic                    o_wr_err
);

  localparam int ADDR_WIDTH = LAYER_WIDTH + OFFSET_WIDTH;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [LAYER_WIDTH:0] LAYER_LIMIT = (LAYER_WIDTH + 1)'(NUM_LAYERS);

  typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;
  typedef enum logic {WR_IDLE, WR_BURST} wr_state_t;

  // Storage is deliberately not reset: a reset only aborts traffic.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  rd_state_t               rd_state, rd_state_nxt;
  logic [LAYER_WIDTH-1:0]  rd_layer;
  logic [OFFSET_WIDTH-1:0] rd_addr;
  logic [BURST_WIDTH-1:0]  rd_left;
  logic                    rd_err;
  logic                    rd_legal, rd_accept, rd_reject;

  wr_state_t               wr_state, wr_state_nxt;
  logic                    wr_mode;
  logic [LAYER_WIDTH-1:0]  wr_layer;
  logic [OFFSET_WIDTH-1:0] wr_addr;
  logic [BURST_WIDTH-1:0]  wr_left;
  logic                    wr_done, wr_err;
  logic                    wr_legal, wr_accept, wr_reject, wr_commit, wr_final;
  logic [ADDR_WIDTH-1:0]   wr_idx;

  assign rd_legal = {1'b0, i_rd_layer} < LAYER_LIMIT;
  assign wr_legal = {1'b0, i_wr_layer} < LAYER_LIMIT;
  assign wr_idx   = {wr_layer, wr_addr};

  // Read state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_state <= RD_IDLE;
    else     rd_state <= rd_state_nxt;
  end

  // Read next state: accept legal requests when idle, leave burst on the final beat
  always_comb begin
    rd_state_nxt = rd_state;
    rd_accept    = 1'b0;
    rd_reject    = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (i_rd_req && rd_legal) begin
          rd_accept    = 1'b1;
          rd_state_nxt = RD_BURST;
        end else if (i_rd_req) begin
          rd_reject = 1'b1;
        end
      end
      RD_BURST: begin
        if (rd_left == '0) rd_state_nxt = RD_IDLE;
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // Read context: latch on acceptance, then step offset (wrapping inside the layer) once per beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_layer <= '0;
      rd_addr  <= '0;
      rd_left  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_err <= rd_reject;
      if (rd_accept) begin
        rd_layer <= i_rd_layer;
        rd_addr  <= i_rd_addr;
        rd_left  <= i_rd_len;
      end else if (rd_state == RD_BURST) begin
        rd_addr <= rd_addr + 1'b1;
        rd_left <= rd_left - 1'b1;
      end
    end
  end

  // Beat outputs are forced to zero outside a burst; data read is combinational, so a
  // same-cycle write commit to the beat address is seen only from the next cycle.
  assign o_rd_ready = (rd_state == RD_IDLE);
  assign o_rd_valid = (rd_state == RD_BURST);
  assign o_rd_last  = o_rd_valid && (rd_left == '0);
  assign o_rd_layer = o_rd_valid ? rd_layer : '0;
  assign o_rd_addr  = o_rd_valid ? rd_addr : '0;
  assign o_rd_data  = o_rd_valid ? mem[{rd_layer, rd_addr}] : '0;
  assign o_rd_err   = rd_err;

  // Write state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_state <= WR_IDLE;
    else     wr_state <= wr_state_nxt;
  end

  // Write next state: accept legal requests when idle, commit on valid beats, leave after the last one
  always_comb begin
    wr_state_nxt = wr_state;
    wr_accept    = 1'b0;
    wr_reject    = 1'b0;
    wr_commit    = 1'b0;
    wr_final     = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (i_wr_req && wr_legal) begin
          wr_accept    = 1'b1;
          wr_state_nxt = WR_BURST;
        end else if (i_wr_req) begin
          wr_reject = 1'b1;
        end
      end
      WR_BURST: begin
        wr_commit = i_wr_valid;
        if (i_wr_valid && (wr_left == '0)) begin
          wr_final     = 1'b1;
          wr_state_nxt = WR_IDLE;
        end
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  // Write context: latch on acceptance, step offset per committed beat, pulse done/err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_mode  <= 1'b0;
      wr_layer <= '0;
      wr_addr  <= '0;
      wr_left  <= '0;
      wr_done  <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      wr_done <= wr_final;
      wr_err  <= wr_reject;
      if (wr_accept) begin
        wr_mode  <= i_wr_mode;
        wr_layer <= i_wr_layer;
        wr_addr  <= i_wr_addr;
        wr_left  <= i_wr_len;
      end else if (wr_commit) begin
        wr_addr <= wr_addr + 1'b1;
        wr_left <= wr_left - 1'b1;
      end
    end
  end

  // Commit one word per valid beat: overwrite, or wrapping add for accumulate
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[wr_idx] <= wr_mode ? (mem[wr_idx] + i_wr_data) : i_wr_data;
    end
  end

  assign o_wr_ready = (wr_state == WR_IDLE);
  assign o_wr_done  = wr_done;
  assign o_wr_err   = wr_err;

endmodule

// File: tb/tb_ann_burst_memory.sv
// tb_ann_burst_memory: randomized and directed traffic against a word-array reference model.
// Read beats are predicted at request time and checked by an independent negedge monitor.
// Write handshakes (ready, done, err) are checked inline by the driving tasks.
module tb_ann_burst_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd_req;
  logic [1:0]  i_rd_layer;
  logic [10:0] i_rd_addr;
  logic [5:0]  i_rd_len;
  logic        o_rd_ready, o_rd_valid, o_rd_last, o_rd_err;
  logic [1:0]  o_rd_layer;
  logic [10:0] o_rd_addr;
  logic [31:0] o_rd_data;
  logic        i_wr_req, i_wr_mode, i_wr_valid;
  logic [1:0]  i_wr_layer;
  logic [10:0] i_wr_addr;
  logic [5:0]  i_wr_len;
  logic [31:0] i_wr_data;
  logic        o_wr_ready, o_wr_done, o_wr_err;

  ann_burst_memory dut (
    .clk(clk), .rst(rst),
    .i_rd_req(i_rd_req), .i_rd_layer(i_rd_layer), .i_rd_addr(i_rd_addr), .i_rd_len(i_rd_len),
    .o_rd_ready(o_rd_ready), .o_rd_valid(o_rd_valid), .o_rd_layer(o_rd_layer),
    .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last), .o_rd_err(o_rd_err),
    .i_wr_req(i_wr_req), .i_wr_mode(i_wr_mode), .i_wr_layer(i_wr_layer), .i_wr_addr(i_wr_addr),
    .i_wr_len(i_wr_len), .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data),
    .o_wr_ready(o_wr_ready), .o_wr_done(o_wr_done), .o_wr_err(o_wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  layer;
    logic [10:0] addr;
    logic [31:0] data;
    logic        last;
    bit          chk_data;
  } rd_beat_t;

  rd_beat_t    rd_exp[$];
  logic [31:0] mdl   [8192];
  bit          known [8192];
  logic [31:0] wbuf  [64];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every presented read beat must match the oldest prediction, with no gaps inside a burst
  logic prev_mid = 1'b0;
  always @(negedge clk) begin : mon
    rd_beat_t e;
    if (rst) begin
      prev_mid = 1'b0;
    end else begin
      if (prev_mid) chk("rd_no_gap", {31'd0, o_rd_valid}, 32'd1);
      if (o_rd_valid) begin
        if (rd_exp.size() == 0) begin
          chk("rd_unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = rd_exp.pop_front();
          chk("rd_layer", {30'd0, o_rd_layer}, {30'd0, e.layer});
          chk("rd_addr", {21'd0, o_rd_addr}, {21'd0, e.addr});
          chk("rd_last", {31'd0, o_rd_last}, {31'd0, e.last});
          if (e.chk_data) chk("rd_data", o_rd_data, e.data);
        end
      end
      prev_mid = o_rd_valid && !o_rd_last;
    end
  end

  // Issue one read burst; predictions come straight from the word array with offsets taken modulo 2048
  task automatic do_read(input logic [1:0] layer, input logic [10:0] addr, input logic [5:0] len);
    int t = 0;
    rd_beat_t e;
    logic [10:0] a;
    @(negedge clk);
    while (!o_rd_ready && t < 300) begin @(negedge clk); t++; end
    chk("rd_ready_wait", {31'd0, o_rd_ready}, 32'd1);
    i_rd_req = 1'b1; i_rd_layer = layer; i_rd_addr = addr; i_rd_len = len;
    if (layer < 2'd3) begin
      for (int b = 0; b <= int'(len); b++) begin
        a = 11'((int'(addr) + b) % 2048);
        e.layer = layer; e.addr = a; e.data = mdl[{layer, a}];
        e.chk_data = known[{layer, a}]; e.last = (b == int'(len));
        rd_exp.push_back(e);
      end
    end
    @(posedge clk); #1;
    i_rd_req = 1'b0;
  endtask

  // Issue one write burst from wbuf, with optional idle gaps; the model updates at each commit edge
  task automatic do_write(input logic mode, input logic [1:0] layer, input logic [10:0] addr,
                          input logic [5:0] len, input int gap_pct, input int gap_beat);
    int t = 0;
    logic [12:0] idx;
    @(negedge clk);
    while (!o_wr_ready && t < 300) begin @(negedge clk); t++; end
    chk("wr_ready_wait", {31'd0, o_wr_ready}, 32'd1);
    i_wr_req = 1'b1; i_wr_mode = mode; i_wr_layer = layer; i_wr_addr = addr; i_wr_len = len;
    @(posedge clk); #1;
    i_wr_req = 1'b0;
    chk("wr_ready_low", {31'd0, o_wr_ready}, 32'd0);
    for (int b = 0; b <= int'(len); b++) begin
      if (b == gap_beat || $urandom_range(0, 99) < gap_pct) begin
        i_wr_valid = 1'b0;
        @(posedge clk); #1;
      end
      i_wr_valid = 1'b1;
      i_wr_data  = wbuf[b];
      @(posedge clk);
      idx = {layer, 11'((int'(addr) + b) % 2048)};
      mdl[idx]   = mode ? mdl[idx] + wbuf[b] : wbuf[b];
      known[idx] = mode ? known[idx] : 1'b1;
      #1;
    end
    i_wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_done_pulse", {31'd0, o_wr_done}, 32'd1);
    chk("wr_ready_with_done", {31'd0, o_wr_ready}, 32'd1);
    @(negedge clk);
    chk("wr_done_single", {31'd0, o_wr_done}, 32'd0);
  endtask

  task automatic drain();
    int t = 0;
    while ((rd_exp.size() != 0 || !o_rd_ready) && t < 400) begin @(negedge clk); t++; end
    chk("rd_drain_left", rd_exp.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lwi, lri, t;
    logic [31:0] d2;
    rst = 1'b1;
    i_rd_req = 0; i_rd_layer = 0; i_rd_addr = 0; i_rd_len = 0;
    i_wr_req = 0; i_wr_mode = 0; i_wr_layer = 0; i_wr_addr = 0; i_wr_len = 0;
    i_wr_valid = 0; i_wr_data = 0;
    #12;
    chk("rst_rd_ready", {31'd0, o_rd_ready}, 32'd1);
    chk("rst_wr_ready", {31'd0, o_wr_ready}, 32'd1);
    chk("rst_rd_valid", {31'd0, o_rd_valid}, 32'd0);
    chk("rst_rd_last", {31'd0, o_rd_last}, 32'd0);
    chk("rst_rd_data", o_rd_data, 32'd0);
    chk("rst_rd_addr", {21'd0, o_rd_addr}, 32'd0);
    chk("rst_errs_done", {29'd0, o_rd_err, o_wr_err, o_wr_done}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Preload offsets 0..255 of every layer
    for (int l = 0; l < 3; l++)
      for (int k = 0; k < 4; k++) begin
        for (int b = 0; b < 64; b++) wbuf[b] = $urandom;
        do_write(1'b0, 2'(l), 11'(k * 64), 6'd63, 0, -1);
      end

    // Overwrite burst with one idle gap, then stray valids while idle, then read back
    wbuf[0] = 10; wbuf[1] = 11; wbuf[2] = 12; wbuf[3] = 13;
    do_write(1'b0, 2'd1, 11'd0, 6'd3, 0, 2);
    i_wr_valid = 1'b1; i_wr_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    i_wr_valid = 1'b0;
    do_read(2'd1, 11'd0, 6'd3);
    drain();
    do_read(2'd1, 11'd4, 6'd0);
    drain();

    // Accumulate, including a signed delta and a wrap past the top of the signed range
    wbuf[0] = 100;          do_write(1'b0, 2'd0, 11'd5, 6'd0, 0, -1);
    wbuf[0] = 32'hFFFF_FFE2; do_write(1'b1, 2'd0, 11'd5, 6'd0, 0, -1);
    do_read(2'd0, 11'd5, 6'd0);
    wbuf[0] = 32'h7FFF_FFFF; do_write(1'b0, 2'd0, 11'd6, 6'd0, 0, -1);
    wbuf[0] = 32'd1;         do_write(1'b1, 2'd0, 11'd6, 6'd0, 0, -1);
    do_read(2'd0, 11'd6, 6'd0);
    drain();

    // Offset wrap inside layer 2
    for (int b = 0; b < 4; b++) wbuf[b] = $urandom;
    do_write(1'b0, 2'd2, 11'd2046, 6'd3, 0, -1);
    do_read(2'd2, 11'd2046, 6'd3);
    drain();

    // Illegal layer on both channels
    do_read(2'd3, 11'd0, 6'd2);
    chk("rd_ready_after_illegal", {31'd0, o_rd_ready}, 32'd1);
    @(negedge clk); chk("rd_err_pulse", {31'd0, o_rd_err}, 32'd1);
    @(negedge clk); chk("rd_err_single", {31'd0, o_rd_err}, 32'd0);
    i_wr_req = 1'b1; i_wr_layer = 2'd3; i_wr_addr = 0; i_wr_len = 0;
    @(posedge clk); #1; i_wr_req = 1'b0;
    chk("wr_ready_after_illegal", {31'd0, o_wr_ready}, 32'd1);
    @(negedge clk); chk("wr_err_pulse", {31'd0, o_wr_err}, 32'd1);
    @(negedge clk); chk("wr_err_single", {31'd0, o_wr_err}, 32'd0);

    // Second write request while busy is ignored
    for (int b = 0; b < 8; b++) wbuf[b] = $urandom;
    fork
      do_write(1'b0, 2'd1, 11'd20, 6'd7, 0, 3);
      begin
        t = 0;
        @(negedge clk);
        while (o_wr_ready && t < 50) begin @(negedge clk); t++; end
        i_wr_req = 1'b1; i_wr_mode = 1'b1; i_wr_layer = 2'd0; i_wr_addr = 11'd200; i_wr_len = 6'd0;
        repeat (2) @(negedge clk);
        i_wr_req = 1'b0;
      end
    join
    do_read(2'd1, 11'd20, 6'd7);
    do_read(2'd0, 11'd200, 6'd3);
    drain();

    // Read/write collision on one address: old word first, new word afterwards
    wbuf[0] = 5; do_write(1'b0, 2'd1, 11'd7, 6'd0, 0, -1);
    @(negedge clk);
    i_wr_req = 1'b1; i_wr_mode = 1'b0; i_wr_layer = 2'd1; i_wr_addr = 11'd7; i_wr_len = 6'd0;
    @(posedge clk); #1; i_wr_req = 1'b0;
    do_read(2'd1, 11'd7, 6'd0);
    i_wr_valid = 1'b1; i_wr_data = 32'd9;
    @(posedge clk);
    mdl[{2'd1, 11'd7}] = 32'd9;
    #1; i_wr_valid = 1'b0;
    do_read(2'd1, 11'd7, 6'd0);
    drain();

    // Randomized concurrent traffic on distinct layers
    for (int it = 0; it < 30; it++) begin
      lwi = $urandom_range(0, 2);
      lri = (lwi + 1 + $urandom_range(0, 1)) % 3;
      for (int b = 0; b < 64; b++) wbuf[b] = $urandom;
      fork
        do_write(1'($urandom_range(0, 1)), 2'(lwi), 11'($urandom_range(0, 2047)),
                 6'($urandom_range(0, 63)), 25, -1);
        do_read(2'(lri), 11'($urandom_range(0, 192)), 6'($urandom_range(0, 63)));
      join
      drain();
    end

    // Reset in the middle of a write burst and a read burst
    do_read(2'd0, 11'd0, 6'd40);
    @(negedge clk);
    i_wr_req = 1'b1; i_wr_mode = 1'b0; i_wr_layer = 2'd1; i_wr_addr = 11'd100; i_wr_len = 6'd3;
    @(posedge clk); #1; i_wr_req = 1'b0;
    i_wr_valid = 1'b1; i_wr_data = 32'hA1A1_0001;
    @(posedge clk); mdl[{2'd1, 11'd100}] = 32'hA1A1_0001; #1;
    i_wr_data = 32'hA1A1_0002;
    @(posedge clk); mdl[{2'd1, 11'd101}] = 32'hA1A1_0002; #1;
    d2 = 32'hA1A1_0003;
    i_wr_data = d2;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_wr_ready", {31'd0, o_wr_ready}, 32'd1);
    chk("rst_mid_rd_valid", {31'd0, o_rd_valid}, 32'd0);
    chk("rst_mid_rd_ready", {31'd0, o_rd_ready}, 32'd1);
    rd_exp.delete();
    @(posedge clk); @(posedge clk); #1;
    i_wr_valid = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    do_read(2'd1, 11'd100, 6'd3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ann_burst_memory.md
Name: ann_burst_memory

Overview:
- Parametrised successor to the ANN data/weight RAM pair: one layer-indexed parameter memory with independent burst read and burst write channels.
- Write channel supports overwrite and accumulate modes, so gradient/delta terms are added in place during DQN weight update.
- Sits between the ANN datapath (feed-forward, back-propagation, update engines) and storage; instantiated once for weights and once for activations/deltas.

Parameters:
- DATA_WIDTH, 32, word width; two's-complement fixed-point in accumulate mode.
- LAYER_WIDTH, 2, layer index width.
- NUM_LAYERS, 3, number of valid layers; layer index >= NUM_LAYERS is illegal.
- OFFSET_WIDTH, 11, word offset width within one layer region.
- BURST_WIDTH, 6, burst length field width; length encoded as beats-1, so max burst is 2**BURST_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_rd_req  in  1  read burst request; accepted when o_rd_ready=1.
- i_rd_layer  in  LAYER_WIDTH  read layer.
- i_rd_addr  in  OFFSET_WIDTH  read start offset.
- i_rd_len  in  BURST_WIDTH  read beats-1.
- o_rd_ready  out  1  read channel idle.
- o_rd_valid  out  1  read beat valid.
- o_rd_layer  out  LAYER_WIDTH  layer of beat.
- o_rd_addr  out  OFFSET_WIDTH  offset of beat.
- o_rd_data  out  DATA_WIDTH  read word.
- o_rd_last  out  1  final beat of burst.
- o_rd_err  out  1  one-cycle pulse: illegal layer, request dropped.
- i_wr_req  in  1  write burst request; accepted when o_wr_ready=1.
- i_wr_mode  in  1  0 overwrite, 1 accumulate.
- i_wr_layer  in  LAYER_WIDTH  write layer.
- i_wr_addr  in  OFFSET_WIDTH  write start offset.
- i_wr_len  in  BURST_WIDTH  write beats-1.
- i_wr_valid  in  1  write beat valid.
- i_wr_data  in  DATA_WIDTH  write word.
- o_wr_ready  out  1  write channel idle.
- o_wr_done  out  1  one-cycle pulse after the last beat is committed.
- o_wr_err  out  1  one-cycle pulse: illegal layer, request dropped.

Behaviour:
- Storage: register array of 2**(LAYER_WIDTH+OFFSET_WIDTH) words, addressed by {layer, offset}. Contents are not reset.
- Reset (async): both FSMs go to IDLE. o_rd_ready=1, o_wr_ready=1. All other outputs are 0.
- Read FSM, IDLE -> BURST:
  - i_rd_req=1 in IDLE with a legal layer latches layer, start offset and len. o_rd_ready goes 0 the next cycle.
  - The first beat appears on o_rd_valid in the cycle after acceptance.
  - One beat per cycle with no gaps; len+1 beats total; o_rd_last is set on the final beat.
  - FSM returns to IDLE with that final beat, and o_rd_ready=1 in the following cycle.
- Write FSM, IDLE -> BURST:
  - i_wr_req=1 in IDLE with a legal layer latches mode, layer, offset and len. o_wr_ready goes 0 the next cycle.
  - i_wr_valid beats are accepted only in BURST. Gaps are allowed; one word is committed per valid cycle at the current offset.
  - Overwrite commits mem = i_wr_data. Accumulate commits mem = mem + i_wr_data, truncated to DATA_WIDTH (wraps, no saturation).
  - After beat len+1: o_wr_done pulses the next cycle, FSM returns to IDLE, and o_wr_ready=1 the same cycle as o_wr_done.
- i_wr_valid in IDLE is ignored. i_rd_req/i_wr_req while not ready are ignored, with no queueing.
- Address generation: offset increments by 1 per beat modulo 2**OFFSET_WIDTH. It wraps within the same layer and never carries into the layer field.
- Illegal layer (>= NUM_LAYERS): request not accepted, FSM stays IDLE, matching *_err pulses the next cycle.
- Same-cycle collision: a read beat and a write commit to the same address return the OLD word (read-before-write). The new value is visible from the next cycle.
- Read and write channels are fully independent and may run concurrently.
- Reset mid-burst aborts both channels immediately. No further writes occur; words already committed remain.

Test Plan:
- Overwrite burst: layer 1, addr 0, len 3, data 10,11,12,13 with one idle gap. Then read the same burst -> beats 10,11,12,13 on 4 consecutive cycles; o_rd_last on the 4th; o_wr_done one cycle after the 4th write.
- Accumulate: preload layer 0, addr 5 = 100. Accumulate len 0 with data -30 -> read returns 70. Add 0x7FFFFFFF to 0x00000001 -> 0x80000000 (wrap).
- Wrap: read layer 2, addr 2046, len 3 -> o_rd_addr 2046, 2047, 0, 1; o_rd_layer stays 2.
- Illegal and busy: i_rd_req with layer 3 -> o_rd_err pulse, no valid beats. A second i_wr_req during a burst is ignored; the first burst completes unchanged.
- Collision: read addr 7 in the same cycle as an overwrite of addr 7 from 5 to 9 -> read returns 5; a read next cycle returns 9.
- Reset mid-burst: assert rst after 2 of 4 write beats -> o_wr_ready=1 and o_rd_valid=0 immediately. Read-back shows beats 1-2 written and 3-4 unchanged.
